icache_dm_refill: RTL and testbench
===================================

# icache_dm_refill

Parametrised direct-mapped instruction cache with an integrated miss/refill state machine, sitting between the fetch-stage PC and the instruction-memory port. Hits return the addressed word one cycle after the request is accepted. Misses issue a line-aligned memory request, wait for the full line, install it and then return the word. Supports whole-cache flush and optional hit/miss statistics counters.

## Interface
- ADDR_W, 32, fetch address width (bits)
- NLINES, 4, number of cache lines; power of two, ≥2
- LINE_W, 128, line width (bits); power of two, multiple of WORD_W
- WORD_W, 32, instruction width (bits)
- Derived: OFF_W=log2(LINE_W/8), IDX_W=log2(NLINES), TAG_W=ADDR_W-IDX_W-OFF_W, WSEL=addr[OFF_W-1:log2(WORD_W/8)]

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- flush  in  1  invalidate all lines
- req_valid  in  1  fetch request
- req_ready  out  1  high only in IDLE
- req_addr  in  ADDR_W  byte address, word-aligned
- rsp_valid  out  1  one-cycle pulse, rsp_instr valid
- rsp_instr  out  WORD_W  fetched instruction
- rsp_hit  out  1  qualifies rsp_valid: 1=hit, 0=serviced by refill
- mem_req_valid  out  1  refill request, held until accepted
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  line-aligned address (low OFF_W bits zero)
- mem_rsp_valid  in  1  refill line present
- mem_rsp_data  in  LINE_W  refill line; word w at bits [w*WORD_W +: WORD_W]

## Operation
- Req accepted when req_valid & req_ready; address latched; tag/index/word split as above.
- FSM states: IDLE, MREQ, MWAIT, FILL.
- IDLE: on accepted req, hit (valid[idx] & tag match) -> stay in IDLE, rsp_valid=1, rsp_hit=1 next cycle. Miss -> MREQ.
- MREQ: mem_req_valid=1, mem_req_addr={tag,idx,OFF_W'b0}; on mem_req_ready -> MWAIT.
- MWAIT: on mem_rsp_valid, capture line -> FILL.
- FILL: write data/tag, set valid[idx], rsp_valid=1, rsp_hit=0, rsp_instr=selected word from the filled line; -> IDLE.
- flush: clears all valid bits at the clock edge, in any state. If flush is asserted during MREQ/MWAIT/FILL, the pending refill still completes and responds, but valid[idx] is left clear (refill from before the flush is not cached). A simultaneous accepted request in IDLE is treated as a miss.
- mem_rsp_valid outside MWAIT is ignored. mem_req_ready outside MREQ is ignored.
- Reset: FSM->IDLE, all valid bits cleared. rsp_valid, rsp_hit, mem_req_valid reset to 0; rsp_instr and mem_req_addr reset to 0. Data/tag arrays are not reset. Reset mid-refill abandons it; no response is issued.

## Timing
- Hit latency: 1 cycle (req accepted at edge N, rsp_valid high during cycle N+1). Back-to-back hits run at 1 per cycle.
- Miss: mem_req_valid rises the cycle after acceptance. rsp_valid rises the cycle after the mem_rsp_valid edge. Minimum miss latency is 3 cycles plus memory latency.
- req_ready is low from MREQ through FILL; rises the cycle after FILL.
- mem_req_valid/mem_req_addr stable while mem_req_ready is low.

## Configuration
- ICACHE_STATS_EN defined: adds outputs hit_cnt, miss_cnt (32 bits each).
  - Each counts accepted requests by outcome; saturates at 0xFFFF_FFFF.
  - Cleared by reset, not by flush.
- Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Reset, then req 0x0000_0048 -> miss; mem_req_addr=0x0000_0040. Return line 0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD -> rsp_instr=0xBBBBBBBB, rsp_hit=0.
- Follow-up reqs 0x40, 0x44, 0x4C back-to-back -> three hits on consecutive cycles: 0xDDDDDDDD, 0xCCCCCCCC, 0xAAAAAAAA.
- Req 0x0000_0088 (same index 0, tag 2) -> miss, line replaced; then 0x48 -> miss again.
- Hold mem_req_ready low 5 cycles -> mem_req_valid/addr held stable, req_ready low throughout.
- Flush during MWAIT -> response still delivered; re-request of same address -> miss.
- With ICACHE_STATS_EN, after the first two scenarios -> hit_cnt=3, miss_cnt=1. Reset mid-MWAIT -> no rsp_valid, counters 0.

Source files
------------

// File: rtl/icache_dm_refill_if.sv
// Fetch-side and refill-side buses of the direct-mapped instruction cache.
// A transfer happens on a rising edge with valid & ready both high; valid and payload hold until then. rsp_valid is a one-cycle pulse with no back-pressure.
interface icache_dm_refill_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid;
  logic [WORD_W-1:0] rsp_instr;
  logic              rsp_hit;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_rsp_valid;
  logic [LINE_W-1:0] mem_rsp_data;

  modport slave (
    input  req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output req_ready, rsp_valid, rsp_instr, rsp_hit, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_hit, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with a single-outstanding miss/refill FSM and whole-cache flush.
// Optional hit/miss counters are enabled with the ICACHE_STATS_EN macro.
module icache_dm_refill #(
  parameter int ADDR_W = 32,
  parameter int NLINES = 4,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  icache_dm_refill_if.slave bus,
  output logic [1:0] dbg_state
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(NLINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WB_W   = $clog2(WORD_W / 8);
  localparam int WSEL_W = OFF_W - WB_W;

  typedef enum logic [1:0] {IDLE, MREQ, MWAIT, FILL} state_t;
  state_t state, state_nx;

  logic [TAG_W-1:0]       tag_arr  [NLINES];
  logic [LINE_W-1:0]      data_arr [NLINES];
  logic [NLINES-1:0]      valid_q;
  logic [ADDR_W-1:WB_W]   addr_q;
  logic [LINE_W-1:0]      line_q;
  logic                   fill_ok;
  logic                   rsp_valid, rsp_hit, mem_req_valid;
  logic [WORD_W-1:0]      rsp_instr;
  logic [ADDR_W-1:0]      mem_req_addr;

  logic [IDX_W-1:0]  req_idx, idx_q;
  logic [TAG_W-1:0]  req_tag, tag_q;
  logic [WSEL_W-1:0] req_wsel, wsel_q;
  logic              accept, req_hit;
  logic [WORD_W-1:0] hit_word, fill_word;
  logic              unused_low;

  assign req_idx  = bus.req_addr[OFF_W +: IDX_W];
  assign req_tag  = bus.req_addr[ADDR_W-1 -: TAG_W];
  assign req_wsel = bus.req_addr[OFF_W-1:WB_W];
  assign idx_q    = addr_q[OFF_W +: IDX_W];
  assign tag_q    = addr_q[ADDR_W-1 -: TAG_W];
  assign wsel_q   = addr_q[OFF_W-1:WB_W];
  assign unused_low = ^bus.req_addr[WB_W-1:0];

  assign accept    = (state == IDLE) && bus.req_valid;
  // A flush on the accepting edge forces a miss so no stale line is returned.
  assign req_hit   = valid_q[req_idx] && (tag_arr[req_idx] == req_tag) && !flush;
  assign hit_word  = data_arr[req_idx][int'(req_wsel) * WORD_W +: WORD_W];
  assign fill_word = bus.mem_rsp_data[int'(wsel_q) * WORD_W +: WORD_W];

  assign bus.req_ready     = (state == IDLE);
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_instr     = rsp_instr;
  assign bus.rsp_hit       = rsp_hit;
  assign bus.mem_req_valid = mem_req_valid;
  assign bus.mem_req_addr  = mem_req_addr;
  assign dbg_state         = state;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept && !req_hit) state_nx = MREQ;
      MREQ:    if (bus.mem_req_ready) state_nx = MWAIT;
      MWAIT:   if (bus.mem_rsp_valid) state_nx = FILL;
      FILL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      valid_q       <= '0;
      fill_ok       <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_hit       <= 1'b0;
      rsp_instr     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
    end else begin
      state     <= state_nx;
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          addr_q <= bus.req_addr[ADDR_W-1:WB_W];
          if (req_hit) begin
            rsp_valid <= 1'b1;
            rsp_hit   <= 1'b1;
            rsp_instr <= hit_word;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            fill_ok       <= 1'b1;
          end
        end
        MREQ: if (bus.mem_req_ready) mem_req_valid <= 1'b0;
        MWAIT: if (bus.mem_rsp_valid) begin
          line_q    <= bus.mem_rsp_data;
          rsp_valid <= 1'b1;
          rsp_hit   <= 1'b0;
          rsp_instr <= fill_word;
        end
        FILL: valid_q[idx_q] <= fill_ok;
        default: ;
      endcase
      // Flush wins over a fill on the same edge; a refill that saw a flush is never marked valid.
      if (flush) begin
        valid_q <= '0;
        fill_ok <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == FILL) begin
      tag_arr[idx_q]  <= tag_q;
      data_arr[idx_q] <= line_q;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (req_hit) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_icache_dm_refill.sv
// Bench for icache_dm_refill: directed scenarios plus randomized accesses against a line-level cache model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_icache_dm_refill;
  logic clk = 1'b0;
  logic reset, flush;
  logic [1:0] dbg_state;
  always #5 clk = ~clk;

  icache_dm_refill_if #(.ADDR_W(32), .LINE_W(128), .WORD_W(32)) bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_dm_refill #(.ADDR_W(32), .NLINES(4), .LINE_W(128), .WORD_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus), .dbg_state(dbg_state)
`ifdef ICACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] mem [64];
  bit           m_valid [4];
  logic [25:0]  m_tag [4];
  int           exp_hits, exp_misses;

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [127:0] l;
    l = mem[a[9:4]];
    return l[a[3:2] * 32 +: 32];
  endfunction

  function automatic bit m_lookup(input logic [31:0] a);
    return m_valid[a[5:4]] && (m_tag[a[5:4]] == a[31:6]);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  // One request; serves a refill if the cache misses. seq_ok collects handshake/timing sanity.
  task automatic access(input logic [31:0] a, input int stall, input int lat, input bit fl_req,
                        input bit fl_wait, output bit missed, output bit rv, output logic [31:0] ri,
                        output bit rh, output logic [31:0] ma, output bit seq_ok);
    seq_ok = (bus.req_ready === 1'b1);
    bus.req_valid = 1'b1; bus.req_addr = a; flush = fl_req;
    @(negedge clk);
    bus.req_valid = 1'b0; flush = 1'b0;
    missed = (bus.rsp_valid !== 1'b1);
    ma = bus.mem_req_addr;
    rv = 1'b0; ri = '0; rh = 1'b0;
    if (!missed) begin
      rv = 1'b1; ri = bus.rsp_instr; rh = bus.rsp_hit;
      if (bus.req_ready !== 1'b1) seq_ok = 1'b0;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== ma || bus.req_ready !== 1'b0) seq_ok = 1'b0;
      bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    bus.mem_rsp_valid = 1'b0;
    if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== ma || bus.req_ready !== 1'b0) seq_ok = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    if (fl_wait) begin
      flush = 1'b1; @(negedge clk); flush = 1'b0;
    end
    for (int i = 0; i < lat; i++) begin
      if (bus.rsp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || bus.req_ready !== 1'b0) seq_ok = 1'b0;
      @(negedge clk);
    end
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) seq_ok = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = mem[a[9:4]];
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    rv = bus.rsp_valid; ri = bus.rsp_instr; rh = bus.rsp_hit;
    if (bus.req_ready !== 1'b0) seq_ok = 1'b0;
    @(negedge clk);
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) seq_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_clear(); exp_hits = 0; exp_misses = 0;
    n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0 || bus.rsp_hit !== 1'b0) begin n_err++; $display("FAIL reset_rsp: got valid=%b hit=%b want 0 0", bus.rsp_valid, bus.rsp_hit); end
    n_vec++; if (bus.rsp_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", bus.rsp_instr); end
    n_vec++; if (bus.mem_req_valid !== 1'b0 || bus.mem_req_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_req: got v=%b a=%h want 0 0", bus.mem_req_valid, bus.mem_req_addr); end
`ifdef ICACHE_STATS_EN
    n_vec++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
`endif
  endtask

  task automatic test_first_miss();
    bit missed, rv, rh, ok; logic [31:0] ri, ma;
    access(32'h48, 0, 2, 1'b0, 1'b0, missed, rv, ri, rh, ma, ok);
    n_vec++; if (missed !== 1'b1) begin n_err++; $display("FAIL first_is_miss: got %b want 1", missed); end
    n_vec++; if (ma !== 32'h40) begin n_err++; $display("FAIL first_mem_addr: got %h want 00000040", ma); end
    n_vec++; if (rv !== 1'b1 || ri !== 32'hBBBBBBBB || rh !== 1'b0) begin n_err++; $display("FAIL first_rsp: got v=%b i=%h h=%b want 1 bbbbbbbb 0", rv, ri, rh); end
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL first_seq: got %b want 1", ok); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    logic [31:0] words [3];
    addrs = '{32'h40, 32'h44, 32'h4C};
    words = '{32'hDDDDDDDD, 32'hCCCCCCCC, 32'hAAAAAAAA};
    for (int i = 0; i < 3; i++) begin
      bus.req_valid = 1'b1; bus.req_addr = addrs[i];
      @(negedge clk);
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== 1'b1 || bus.rsp_instr !== words[i]) begin
        n_err++; $display("FAIL b2b_hit%0d: got v=%b h=%b i=%h want 1 1 %h", i, bus.rsp_valid, bus.rsp_hit, bus.rsp_instr, words[i]);
      end
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
`ifdef ICACHE_STATS_EN
    n_vec++; if (hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin n_err++; $display("FAIL b2b_cnt: got %0d/%0d want 3/1", hit_cnt, miss_cnt); end
`endif
  endtask

  task automatic test_replace();
    bit missed, rv, rh, ok; logic [31:0] ri, ma;
    access(32'h88, 1, 1, 1'b0, 1'b0, missed, rv, ri, rh, ma, ok);
    n_vec++; if (missed !== 1'b1 || ma !== 32'h80 || ri !== exp_word(32'h88) || rh !== 1'b0) begin n_err++; $display("FAIL replace_88: got m=%b a=%h i=%h h=%b want 1 80 %h 0", missed, ma, ri, rh, exp_word(32'h88)); end
    access(32'h48, 0, 0, 1'b0, 1'b0, missed, rv, ri, rh, ma, ok);
    n_vec++; if (missed !== 1'b1 || ma !== 32'h40 || ri !== 32'hBBBBBBBB || rh !== 1'b0) begin n_err++; $display("FAIL replace_48: got m=%b a=%h i=%h h=%b want 1 40 bbbbbbbb 0", missed, ma, ri, rh); end
  endtask

  task automatic test_stall();
    bit missed, rv, rh, ok; logic [31:0] ri, ma;
    access(32'h54, 5, 1, 1'b0, 1'b0, missed, rv, ri, rh, ma, ok);
    n_vec++; if (ok !== 1'b1 || missed !== 1'b1 || ma !== 32'h50) begin n_err++; $display("FAIL stall_hold: got ok=%b m=%b a=%h want 1 1 50", ok, missed, ma); end
    n_vec++; if (rv !== 1'b1 || ri !== exp_word(32'h54)) begin n_err++; $display("FAIL stall_rsp: got v=%b i=%h want 1 %h", rv, ri, exp_word(32'h54)); end
  endtask

  task automatic test_flush();
    bit missed, rv, rh, ok; logic [31:0] ri, ma;
    access(32'h54, 0, 0, 1'b0, 1'b0, missed, rv, ri, rh, ma, ok);
    n_vec++; if (missed !== 1'b0 || rh !== 1'b1) begin n_err++; $display("FAIL pre_flush_hit: got m=%b h=%b want 0 1", missed, rh); end
    access(32'h64, 0, 2, 1'b0, 1'b1, missed, rv, ri, rh, ma, ok);
    n_vec++; if (rv !== 1'b1 || ri !== exp_word(32'h64) || rh !== 1'b0 || ok !== 1'b1) begin n_err++; $display("FAIL flush_mwait_rsp: got v=%b i=%h h=%b ok=%b want 1 %h 0 1", rv, ri, rh, ok, exp_word(32'h64)); end
    access(32'h64, 0, 0, 1'b0, 1'b0, missed, rv, ri, rh, ma, ok);
    n_vec++; if (missed !== 1'b1 || rh !== 1'b0) begin n_err++; $display("FAIL flush_rerequest: got m=%b h=%b want 1 0", missed, rh); end
    access(32'h54, 0, 0, 1'b0, 1'b0, missed, rv, ri, rh, ma, ok);
    n_vec++; if (missed !== 1'b1) begin n_err++; $display("FAIL flush_cleared_54: got m=%b want 1", missed); end
    access(32'h54, 0, 0, 1'b1, 1'b0, missed, rv, ri, rh, ma, ok);
    n_vec++; if (missed !== 1'b1 || ri !== exp_word(32'h54)) begin n_err++; $display("FAIL flush_with_req: got m=%b i=%h want 1 %h", missed, ri, exp_word(32'h54)); end
  endtask

  task automatic test_random();
    bit missed, rv, rh, ok, fl_req, fl_wait, exp_hit; logic [31:0] a, ri, ma;
    test_reset();
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
      fl_req = ($urandom_range(0, 9) == 0);
      fl_wait = ($urandom_range(0, 7) == 0);
      if (fl_req) m_clear();
      exp_hit = m_lookup(a);
      access(a, $urandom_range(0, 3), $urandom_range(0, 3), fl_req, fl_wait, missed, rv, ri, rh, ma, ok);
      n_vec++;
      if (missed !== !exp_hit || rv !== 1'b1 || rh !== exp_hit || ri !== exp_word(a) || ok !== 1'b1 ||
          (!exp_hit && ma !== {a[31:4], 4'h0})) begin
        n_err++; $display("FAIL rand%0d a=%h: got m=%b v=%b h=%b i=%h ma=%h ok=%b want m=%b v=1 h=%b i=%h ma=%h ok=1",
                          n, a, missed, rv, rh, ri, ma, ok, !exp_hit, exp_hit, exp_word(a), {a[31:4], 4'h0});
      end
      if (exp_hit) exp_hits++;
      else begin
        exp_misses++;
        if (fl_wait || fl_req) m_clear();
        m_valid[a[5:4]] = !(fl_wait || fl_req);
        m_tag[a[5:4]] = a[31:6];
      end
      if ($urandom_range(0, 11) == 0) begin
        flush = 1'b1; @(negedge clk); flush = 1'b0; m_clear();
      end
    end
`ifdef ICACHE_STATS_EN
    n_vec++; if (hit_cnt !== exp_hits || miss_cnt !== exp_misses) begin n_err++; $display("FAIL rand_cnt: got %0d/%0d want %0d/%0d", hit_cnt, miss_cnt, exp_hits, exp_misses); end
`endif
  endtask

  task automatic test_reset_mid_refill();
    bit missed, rv, rh, ok, quiet; logic [31:0] ri, ma;
    access(32'h2C8, 0, 0, 1'b0, 1'b0, missed, rv, ri, rh, ma, ok);
    bus.req_valid = 1'b1; bus.req_addr = 32'h1C8;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = mem[6'h1C];
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      if (bus.rsp_valid !== 1'b0) quiet = 1'b0;
    end
    m_clear();
    n_vec++; if (quiet !== 1'b1 || bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0) begin n_err++; $display("FAIL reset_mid_refill: got quiet=%b rdy=%b mv=%b want 1 1 0", quiet, bus.req_ready, bus.mem_req_valid); end
`ifdef ICACHE_STATS_EN
    n_vec++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_err++; $display("FAIL reset_mid_cnt: got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
`endif
    access(32'h2C8, 0, 0, 1'b0, 1'b0, missed, rv, ri, rh, ma, ok);
    n_vec++; if (missed !== 1'b1 || ri !== exp_word(32'h2C8)) begin n_err++; $display("FAIL after_reset_miss: got m=%b i=%h want 1 %h", missed, ri, exp_word(32'h2C8)); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[4] = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
    test_reset();
    test_first_miss();
    test_back_to_back();
    test_replace();
    test_stall();
    test_flush();
    test_random();
    test_reset_mid_refill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
